// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        GS_ON   = 2'd0,
        GS_OFF  = 2'd1,
        GS_WAKE = 2'd2
    } gate_state_e;

    localparam int GATE_IDLE_W_DEF   = 8;
    localparam int GATE_WAKE_CYC_DEF = 2;
    localparam int GATE_STAT_W_DEF   = 16;
    localparam int GATE_WAKE_W       = 4;

endpackage

// File: rtl/icg_enable_ctrl.sv
// Drives the ICG enable: gates the downstream clock after a programmable idle
// run and reopens it on wake/activity, flagging clk_ready after a fixed latency.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   GS_ON   | clock running and settled; counting consecutive idle cycles
//   GS_OFF  | clock gated; waiting for any wake source
//   GS_WAKE | clock re-enabled, waiting WAKE_CYC cycles before clk_ready
module icg_enable_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W   = GATE_IDLE_W_DEF,
    parameter int WAKE_CYC = GATE_WAKE_CYC_DEF,
    parameter int STAT_W   = GATE_STAT_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_en,
    input  logic [IDLE_W-1:0] cfg_idle_thr,
    input  logic              force_on,
    input  logic              activity,
    input  logic              wake_req,
    output logic              icg_enable,
    output logic              clk_ready,
    output logic              gated,
    output logic [STAT_W-1:0] gate_cnt
);

    localparam logic [GATE_WAKE_W-1:0] WAKE_LAST =
        (WAKE_CYC > 0) ? GATE_WAKE_W'(WAKE_CYC - 1) : '0;

    gate_state_e             state_q, state_d;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [GATE_WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
    logic [STAT_W-1:0]       gate_cnt_q, gate_cnt_d;

    logic                    idle;
    logic                    wake_any;
    logic [IDLE_W-1:0]       thr_eff;
    logic [IDLE_W:0]         idle_sum;
    logic [IDLE_W-1:0]       idle_sat;

    always_comb begin
        idle     = cfg_en & ~force_on & ~activity & ~wake_req;
        wake_any = wake_req | activity | force_on | ~cfg_en;
        thr_eff  = (cfg_idle_thr == '0) ? IDLE_W'(1) : cfg_idle_thr;
        // One bit wider so the threshold compare cannot be fooled by wrap.
        idle_sum = {1'b0, idle_cnt_q} + (IDLE_W + 1)'(1);
        idle_sat = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        gate_cnt_d = gate_cnt_q;

        case (state_q)
            GS_ON: begin
                if (idle) begin
                    if (idle_sum >= {1'b0, thr_eff}) begin
                        state_d    = GS_OFF;
                        idle_cnt_d = '0;
                        if (gate_cnt_q != '1) begin
                            gate_cnt_d = gate_cnt_q + STAT_W'(1);
                        end
                    end else begin
                        idle_cnt_d = idle_sat;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end

            GS_OFF: begin
                if (wake_any) begin
                    wake_cnt_d = '0;
                    state_d    = (WAKE_CYC == 0) ? GS_ON : GS_WAKE;
                end
            end

            GS_WAKE: begin
                // Inputs are deliberately ignored until the clock has settled.
                wake_cnt_d = wake_cnt_q + GATE_WAKE_W'(1);
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = GS_ON;
                end
            end

            default: begin
                state_d    = GS_ON;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= GS_ON;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_cnt_q <= '0;
            icg_enable <= 1'b1;
            clk_ready  <= 1'b1;
            gated      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            icg_enable <= (state_d != GS_OFF);
            clk_ready  <= (state_d == GS_ON);
            gated      <= (state_d == GS_OFF);
        end
    end

    assign gate_cnt = gate_cnt_q;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Scoreboard bench for icg_enable_ctrl: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural model of the gating rules.
module tb_icg_enable_ctrl;

    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;
    localparam int STAT_W   = 6;
    localparam int STAT_MAX = (1 << STAT_W) - 1;
    localparam int IDLE_MAX = (1 << IDLE_W) - 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_en;
    logic [IDLE_W-1:0] cfg_idle_thr;
    logic              force_on;
    logic              activity;
    logic              wake_req;
    logic              icg_enable;
    logic              clk_ready;
    logic              gated;
    logic [STAT_W-1:0] gate_cnt;

    icg_enable_ctrl #(
        .IDLE_W  (IDLE_W),
        .WAKE_CYC(WAKE_CYC),
        .STAT_W  (STAT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_en      (cfg_en),
        .cfg_idle_thr(cfg_idle_thr),
        .force_on    (force_on),
        .activity    (activity),
        .wake_req    (wake_req),
        .icg_enable  (icg_enable),
        .clk_ready   (clk_ready),
        .gated       (gated),
        .gate_cnt    (gate_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              icg;
        logic              rdy;
        logic              gtd;
        logic [STAT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the clock is either off, or on with some cycles of
    // settling still to go; idle_run counts the current run of idle samples.
    bit m_off;
    int m_wake_left;
    int m_idle_run;
    int m_gates;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic ce, input logic [IDLE_W-1:0] thr,
                        input logic fo, input logic act, input logic wr);
        int   th;
        bit   is_idle;
        exp_t e;
        @(negedge clk);
        rstn         = r;
        cfg_en       = ce;
        cfg_idle_thr = thr;
        force_on     = fo;
        activity     = act;
        wake_req     = wr;
        if (!r) begin
            m_off = 0; m_wake_left = 0; m_idle_run = 0; m_gates = 0;
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_off) begin
            if (wr || act || fo || !ce) begin
                m_off = 0;
                m_wake_left = WAKE_CYC;
            end
        end else begin
            is_idle = ce && !fo && !act && !wr;
            th = (thr == 0) ? 1 : int'(thr);
            if (is_idle) begin
                m_idle_run = (m_idle_run < IDLE_MAX) ? m_idle_run + 1 : IDLE_MAX;
                if (m_idle_run >= th) begin
                    m_off = 1;
                    m_idle_run = 0;
                    if (m_gates < STAT_MAX) m_gates++;
                end
            end else begin
                m_idle_run = 0;
            end
        end
        e.icg = !m_off;
        e.rdy = !m_off && (m_wake_left == 0);
        e.gtd = m_off;
        e.cnt = m_gates[STAT_W-1:0];
        exp_q.push_back(e);
    endtask

    // Wait until the outputs reflect the most recently issued step.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_icg_enable", int'(icg_enable), int'(e.icg));
                chk("sb_clk_ready",  int'(clk_ready),  int'(e.rdy));
                chk("sb_gated",      int'(gated),      int'(e.gtd));
                chk("sb_gate_cnt",   int'(gate_cnt),   int'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [IDLE_W-1:0] thr;
        rstn = 1'b0; cfg_en = 1'b1; cfg_idle_thr = 8'd3;
        force_on = 1'b0; activity = 1'b1; wake_req = 1'b0;

        // Reset for three cycles, then release with activity present.
        repeat (3) step(0, 1, 8'd3, 0, 1, 0);
        step(1, 1, 8'd3, 0, 1, 0);
        settle();
        chk("rst_icg_enable", int'(icg_enable), 1);
        chk("rst_clk_ready",  int'(clk_ready),  1);
        chk("rst_gated",      int'(gated),      0);
        chk("rst_gate_cnt",   int'(gate_cnt),   0);

        // Idle threshold of 3: clock drops after the third idle sample.
        step(1, 1, 8'd3, 0, 0, 0);
        step(1, 1, 8'd3, 0, 0, 0);
        settle();
        chk("thr3_still_on", int'(icg_enable), 1);
        step(1, 1, 8'd3, 0, 0, 0);
        settle();
        chk("thr3_icg_off", int'(icg_enable), 0);
        chk("thr3_gated",   int'(gated),      1);
        chk("thr3_cnt",     int'(gate_cnt),   1);

        // Remain off while idle, then a single-cycle wake request.
        repeat (4) step(1, 1, 8'd3, 0, 0, 0);
        step(1, 1, 8'd3, 0, 0, 1);
        settle();
        chk("wake_icg_on",   int'(icg_enable), 1);
        chk("wake_not_rdy",  int'(clk_ready),  0);
        step(1, 1, 8'd3, 0, 0, 0);
        settle();
        chk("wake_rdy_n1",   int'(clk_ready),  0);
        step(1, 1, 8'd3, 0, 1, 0);
        settle();
        chk("wake_rdy_n2",   int'(clk_ready),  1);

        // Threshold 4 with an activity pulse on the third idle sample.
        step(1, 1, 8'd4, 0, 0, 0);
        step(1, 1, 8'd4, 0, 0, 0);
        step(1, 1, 8'd4, 0, 1, 0);
        repeat (3) step(1, 1, 8'd4, 0, 0, 0);
        settle();
        chk("pulse_no_gate", int'(icg_enable), 1);
        step(1, 1, 8'd4, 0, 0, 0);
        settle();
        chk("pulse_gated",   int'(gated),      1);
        chk("pulse_cnt",     int'(gate_cnt),   2);

        // force_on held: wakes and stays on.
        repeat (12) step(1, 1, 8'd1, 1, 0, 0);
        settle();
        chk("force_rdy",     int'(clk_ready), 1);
        chk("force_gated",   int'(gated),     0);

        // cfg_en low behaves the same way.
        step(1, 1, 8'd1, 0, 0, 0);
        repeat (10) step(1, 0, 8'd1, 0, 0, 0);
        settle();
        chk("cfgen_rdy",     int'(clk_ready), 1);
        chk("cfgen_cnt",     int'(gate_cnt),  3);

        // Reset while in WAKE with wake_cnt at 1.
        step(1, 1, 8'd0, 0, 0, 0);
        step(1, 1, 8'd0, 0, 0, 1);
        step(1, 1, 8'd0, 0, 0, 0);
        step(0, 1, 8'd0, 0, 0, 0);
        settle();
        chk("wake_rst_rdy",  int'(clk_ready),  1);
        chk("wake_rst_icg",  int'(icg_enable), 1);
        chk("wake_rst_cnt",  int'(gate_cnt),   0);

        // Drive enough gate events to saturate the statistic counter.
        for (int i = 0; i < STAT_MAX + 6; i++) begin
            step(1, 1, 8'd1, 0, 0, 0);
            step(1, 1, 8'd1, 0, 0, 1);
            step(1, 1, 8'd1, 0, 1, 0);
            step(1, 1, 8'd1, 0, 1, 0);
        end
        settle();
        chk("sat_cnt", int'(gate_cnt), STAT_MAX);

        // Random traffic against the model.
        thr = 8'd2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) thr = IDLE_W'($urandom_range(0, 6));
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 24) != 0),
                 thr,
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) settle();
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
